// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Two combinational read ports with commit bypass; issue renames, commit writes, flush drops renames.
module reg_file_rename #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int ROB_TAG_W  = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush_in,
   input  logic                  issue_en,
   input  logic [REG_ADDR_W-1:0] issue_reg,
   input  logic [ROB_TAG_W-1:0]  issue_tag,
   input  logic                  commit_en,
   input  logic [REG_ADDR_W-1:0] commit_reg,
   input  logic [XLEN-1:0]       commit_val,
   input  logic [ROB_TAG_W-1:0]  commit_tag,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [XLEN-1:0]       rs1_val,
   output logic                  rs1_busy,
   output logic [ROB_TAG_W-1:0]  rs1_tag,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [XLEN-1:0]       rs2_val,
   output logic                  rs2_busy,
   output logic [ROB_TAG_W-1:0]  rs2_tag
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;

   logic [XLEN-1:0]      val  [NUM_REGS];
   logic [ROB_TAG_W-1:0] tag  [NUM_REGS];
   logic [NUM_REGS-1:0]  busy;

   logic commit_ok;
   logic issue_ok;

   assign commit_ok = commit_en && (commit_reg != '0);
   assign issue_ok  = issue_en && !flush_in && (issue_reg != '0);

   // Issue is assigned after the commit clear so a same-register rename wins.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else if (rdy_in) begin
         if (commit_ok) begin
            val[commit_reg] <= commit_val;
            if (busy[commit_reg] && (tag[commit_reg] == commit_tag))
               busy[commit_reg] <= 1'b0;
         end
         if (flush_in) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++)
               tag[i] <= '0;
         end else if (issue_ok) begin
            busy[issue_reg] <= 1'b1;
            tag[issue_reg]  <= issue_tag;
         end
      end
   end

   logic [REG_ADDR_W-1:0] rd_addr [2];
   logic [XLEN-1:0]       rd_val  [2];
   logic                  rd_busy [2];
   logic [ROB_TAG_W-1:0]  rd_tag  [2];

   assign rd_addr[0] = rs1_addr;
   assign rd_addr[1] = rs2_addr;

   // Sources are read before a same-cycle rename, so issue never feeds the read path.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_val[p]  = '0;
         rd_busy[p] = 1'b0;
         rd_tag[p]  = '0;
         if (rd_addr[p] != '0) begin
            if (commit_ok && rdy_in && (commit_reg == rd_addr[p])) begin
               rd_val[p]  = commit_val;
               rd_busy[p] = busy[rd_addr[p]] && (tag[rd_addr[p]] != commit_tag);
            end else begin
               rd_val[p]  = val[rd_addr[p]];
               rd_busy[p] = busy[rd_addr[p]];
            end
            rd_tag[p] = rd_busy[p] ? tag[rd_addr[p]] : '0;
         end
      end
   end

   assign rs1_val  = rd_val[0];
   assign rs1_busy = rd_busy[0];
   assign rs1_tag  = rd_tag[0];
   assign rs2_val  = rd_val[1];
   assign rs2_busy = rd_busy[1];
   assign rs2_tag  = rd_tag[1];

endmodule
